// File: rtl/acc_pkg.sv
// acc_pkg
// Shared definitions for the pool/writeback datapath.
//   state_e     : control states of the writeback engine
//   MAX_DW      : width every lane element is sign-extended to before it is
//                 handed to the signed max helper, so one helper serves any
//                 DATA_WIDTH below it
//   CFG_W       : width of the feature-size configuration ports
//   smax_pick_a : signed max select, true when a is the larger-or-equal operand
package acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_e;

  localparam int unsigned MAX_DW = 64;
  localparam int unsigned CFG_W  = 8;

  // Returning the select instead of the widened value lets callers keep their
  // own narrow element.
  function automatic logic smax_pick_a(input logic signed [MAX_DW-1:0] a,
                                       input logic signed [MAX_DW-1:0] b);
    return (a >= b);
  endfunction

endpackage

// File: rtl/lane_max.sv
// lane_max
// Combinational LANES-wide elementwise signed max of two packed vectors.
// Ports:
//   a_i : LANES elements, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   b_i : same layout as a_i
//   y_o : per-lane signed max(a_i, b_i), same layout
module lane_max
  import acc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 8
) (
  input  logic [LANES*DATA_WIDTH-1:0] a_i,
  input  logic [LANES*DATA_WIDTH-1:0] b_i,
  output logic [LANES*DATA_WIDTH-1:0] y_o
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_WIDTH-1:0]    a_el;
    logic [DATA_WIDTH-1:0]    b_el;
    logic signed [MAX_DW-1:0] a_ext;
    logic signed [MAX_DW-1:0] b_ext;

    assign a_el  = a_i[i*DATA_WIDTH +: DATA_WIDTH];
    assign b_el  = b_i[i*DATA_WIDTH +: DATA_WIDTH];
    // Sign-extend so the shared helper compares two's-complement values.
    assign a_ext = {{(MAX_DW-DATA_WIDTH){a_el[DATA_WIDTH-1]}}, a_el};
    assign b_ext = {{(MAX_DW-DATA_WIDTH){b_el[DATA_WIDTH-1]}}, b_el};
    assign y_o[i*DATA_WIDTH +: DATA_WIDTH] = smax_pick_a(a_ext, b_ext) ? a_el : b_el;
  end

endmodule

// File: rtl/pool_writeback.sv
// pool_writeback
// 2x2 / stride-2 signed max-pool with optional ReLU, writing the pooled
// feature map to BRAM in HWC order at a runtime base address.
// Beats arrive as vertically paired pixel vectors (rows 2*oh and 2*oh+1 of
// one column), ordered channel group outermost, then output row, then input
// column. Even columns are reduced into a hold register; each odd column
// completes a window and issues one registered BRAM write.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : one-cycle pulse, latches cfg_* while idle
//   cfg_in_w/cfg_in_h : input feature width/height (even, nonzero)
//   cfg_group_shift   : log2 of the number of LANES-wide channel groups
//   cfg_base          : output feature base word address
//   cfg_relu          : clamp negative pooled values to zero
//   in_valid/in_ready : input beat handshake, ready only while running
//   in_top/in_bot     : upper/lower row pixel vectors of the same column
//   wr_en/wr_addr/wr_data : BRAM write port (never back-pressured)
//   busy              : high from the cycle after start until after done
//   done              : one-cycle pulse alongside the final write
//   cfg_err           : one-cycle pulse after a rejected start
// ADDR_WIDTH is expected to be at least CFG_W so a group index always fits.
module pool_writeback
  import acc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [7:0]                  cfg_in_w,
  input  logic [7:0]                  cfg_in_h,
  input  logic [2:0]                  cfg_group_shift,
  input  logic [ADDR_WIDTH-1:0]       cfg_base,
  input  logic                        cfg_relu,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_top,
  input  logic [LANES*DATA_WIDTH-1:0] in_bot,
  output logic                        wr_en,
  output logic [ADDR_WIDTH-1:0]       wr_addr,
  output logic [LANES*DATA_WIDTH-1:0] wr_data,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_err
);

  localparam int VW = LANES * DATA_WIDTH;

  state_e state_q, state_d;

  logic [CFG_W-1:0]      in_w_q,   in_w_d;
  logic [CFG_W-2:0]      half_h_q, half_h_d;
  logic [2:0]            shift_q,  shift_d;
  logic [ADDR_WIDTH-1:0] base_q,   base_d;
  logic                  relu_q,   relu_d;

  logic [CFG_W-1:0]      cg_q,  cg_d;
  logic [CFG_W-2:0]      oh_q,  oh_d;
  logic [CFG_W-1:0]      col_q, col_d;
  // The address wraps modulo 2^ADDR_WIDTH, so the pixel index only needs
  // that many bits as well.
  logic [ADDR_WIDTH-1:0] p_q,   p_d;

  logic [VW-1:0]         hold_q, hold_d;

  logic                  wr_en_q,   wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [VW-1:0]         wr_data_q, wr_data_d;
  logic                  cfg_err_q, cfg_err_d;

  logic                  cfg_ok;
  logic                  start_ok;
  logic                  start_bad;
  logic                  fire;
  logic [CFG_W-1:0]      grp_last;
  logic                  col_last;
  logic                  oh_last;
  logic                  cg_last;
  logic                  beat_last;
  logic [VW-1:0]         col_max;
  logic [VW-1:0]         win_max;
  logic [VW-1:0]         pooled;
  logic [ADDR_WIDTH-1:0] pix_addr;

  assign cfg_ok    = (cfg_in_w != '0) && !cfg_in_w[0] && (cfg_in_h != '0) && !cfg_in_h[0];
  assign start_ok  = start && (state_q == IDLE) && cfg_ok;
  assign start_bad = start && (state_q == IDLE) && !cfg_ok;
  assign fire      = in_valid && (state_q == RUN);

  assign grp_last  = (CFG_W'(1) << shift_q) - CFG_W'(1);
  assign col_last  = (col_q == in_w_q - CFG_W'(1));
  assign oh_last   = (oh_q == half_h_q - (CFG_W-1)'(1));
  assign cg_last   = (cg_q == grp_last);
  assign beat_last = col_last && oh_last && cg_last;

  // First reduce the vertical pair, then fold in the held even column.
  lane_max #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES)
  ) u_row_max (
    .a_i (in_top),
    .b_i (in_bot),
    .y_o (col_max)
  );

  lane_max #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES)
  ) u_col_max (
    .a_i (hold_q),
    .b_i (col_max),
    .y_o (win_max)
  );

  for (genvar i = 0; i < LANES; i++) begin : g_relu
    logic [DATA_WIDTH-1:0] el;
    assign el = win_max[i*DATA_WIDTH +: DATA_WIDTH];
    assign pooled[i*DATA_WIDTH +: DATA_WIDTH] = (relu_q && el[DATA_WIDTH-1]) ? '0 : el;
  end

  // HWC layout: pixels are G words apart, the group picks the word within.
  assign pix_addr = base_q + (p_q << shift_q) + ADDR_WIDTH'(cg_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok) state_d = RUN;
      RUN:  if (fire && beat_last) state_d = LAST;
      LAST: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM-decoded outputs
  always_comb begin
    in_ready = (state_q == RUN);
    busy     = (state_q != IDLE);
    done     = (state_q == LAST);
  end

  // Datapath next state: configuration latch, beat counters, hold register
  // and the registered write port.
  always_comb begin
    in_w_d    = in_w_q;
    half_h_d  = half_h_q;
    shift_d   = shift_q;
    base_d    = base_q;
    relu_d    = relu_q;
    cg_d      = cg_q;
    oh_d      = oh_q;
    col_d     = col_q;
    p_d       = p_q;
    hold_d    = hold_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    cfg_err_d = start_bad;

    if (start_ok) begin
      in_w_d   = cfg_in_w;
      half_h_d = cfg_in_h[CFG_W-1:1];
      shift_d  = cfg_group_shift;
      base_d   = cfg_base;
      relu_d   = cfg_relu;
      cg_d     = '0;
      oh_d     = '0;
      col_d    = '0;
      p_d      = '0;
      hold_d   = '0;
    end

    if (fire) begin
      if (!col_q[0]) begin
        hold_d = col_max;
      end else begin
        wr_en_d   = 1'b1;
        wr_addr_d = pix_addr;
        wr_data_d = pooled;
        // Pixel numbering restarts with every channel group.
        p_d       = (col_last && oh_last) ? '0 : p_q + ADDR_WIDTH'(1);
      end

      if (col_last) begin
        col_d = '0;
        if (oh_last) begin
          oh_d = '0;
          cg_d = cg_q + CFG_W'(1);
        end else begin
          oh_d = oh_q + (CFG_W-1)'(1);
        end
      end else begin
        col_d = col_q + CFG_W'(1);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      in_w_q    <= '0;
      half_h_q  <= '0;
      shift_q   <= '0;
      base_q    <= '0;
      relu_q    <= 1'b0;
      cg_q      <= '0;
      oh_q      <= '0;
      col_q     <= '0;
      p_q       <= '0;
      hold_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      in_w_q    <= in_w_d;
      half_h_q  <= half_h_d;
      shift_q   <= shift_d;
      base_q    <= base_d;
      relu_q    <= relu_d;
      cg_q      <= cg_d;
      oh_q      <= oh_d;
      col_q     <= col_d;
      p_q       <= p_d;
      hold_q    <= hold_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: doc/pool_writeback.md
# pool_writeback

Parametrised 2x2/stride-2 max-pool and feature-map writeback engine for the depthwise-separable accelerator. It sits between the intermediate buffer and the feature BRAM write port. It consumes vertically paired pixel vectors of LANES channels, reduces each 2x2 window with signed max and optional ReLU, and issues HWC-layout BRAM writes at a runtime-selected ping-pong base address. It generalises the fixed 8-channel pool and shift-based address logic to arbitrary lane count, data width, feature size and channel-group count.

## Interface
- DATA_WIDTH, 8, bits per channel element, two's complement
- LANES, 8, channels carried per beat and per BRAM word
- ADDR_WIDTH, 12, BRAM write address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches cfg_* in IDLE
- cfg_in_w  in  8  input feature width; even, >=2
- cfg_in_h  in  8  input feature height; even, >=2
- cfg_group_shift  in  3  channel groups = 1<<shift (channels/LANES)
- cfg_base  in  ADDR_WIDTH  output feature base word address
- cfg_relu  in  1  clamp negative results to 0
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid&&in_ready
- in_top  in  LANES*DATA_WIDTH  row 2*oh, column w, lane i at [i*DW +: DW]
- in_bot  in  LANES*DATA_WIDTH  row 2*oh+1, same column
- wr_en  out  1  BRAM write strobe
- wr_addr  out  ADDR_WIDTH  write word address
- wr_data  out  LANES*DATA_WIDTH  pooled vector
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse, coincides with final wr_en
- cfg_err  out  1  one-cycle pulse on rejected start

## Operation
- States: IDLE, RUN, LAST.
- IDLE→RUN on start when in_w, in_h are even and nonzero. Otherwise pulse cfg_err and stay IDLE.
- start outside IDLE is ignored.
- Beat order: cg (0..G-1) outermost, then oh (0..in_h/2-1), then w (0..in_w-1) innermost.
- Even w: hold[i] = max(top[i], bot[i]), signed.
- Odd w: res[i] = max(hold[i], max(top[i], bot[i])). If relu, apply max(res, 0).
- Each odd-w beat produces one write with wr_addr = cfg_base + ((p << cfg_group_shift) + cg).
  - p = oh*(in_w/2) + w/2 is the output pixel index, reset to 0 at each new cg. Track it with a counter; no multiplier.
  - Address arithmetic is modulo 2^ADDR_WIDTH and wraps silently.
- The last beat is cg=G-1, oh=in_h/2-1, w=in_w-1. Accepting it moves RUN→LAST. LAST→IDLE after one cycle.
- No write-side backpressure; the BRAM always accepts.

## Timing
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, cfg_err=0, state IDLE, all counters and hold=0.
- in_ready=1 exactly while in RUN, so throughput is 1 beat/cycle.
- in_valid gaps stall the counters; hold is retained across gaps.
- Latency: wr_en/wr_addr/wr_data are registered and asserted the cycle after the odd-w beat is accepted.
- busy rises the cycle after start and falls the cycle after done.
- done asserts in LAST, concurrent with the last wr_en.
- Total beats = G*(in_h/2)*in_w. Total writes = G*(in_h/2)*(in_w/2).
- cfg_err asserts the cycle after a rejected start.
- rst mid-run: next cycle returns to IDLE with reset values. No partial write or done is issued.
- start in the same cycle as rst is ignored.

## Structure
- Shared package acc_pkg holds:
  - the state enum {IDLE, RUN, LAST};
  - a signed max function on DATA_WIDTH;
  - a localparam for the lane slice helper.
- One sub-module, lane_max: a combinational LANES-wide signed elementwise max of two vectors. It is instantiated twice (row reduce, column reduce); the ReLU clamp lives in the parent.
- Counters are cg, oh, w and p; widths derive from the 8-bit config ports.

## Test plan
- Single-group run: in_w=4, in_h=4, shift=0, base=0x400, relu=0, lane values = row*4+col. Required response: 8 beats → 4 writes at 0x400..0x403, lane data 5, 7, 13, 15; done on the 4th write.
- Channel interleave: in_w=2, in_h=4, shift=1, base=0. Required response: cg0 writes at 0x000 and 0x002; cg1 writes at 0x001 and 0x003.
- Signed and ReLU: window values -5, -3, -7, -128. Required response: wr_data lane = -3 (0xFD) with relu=0, and 0x00 with relu=1.
- Stall: in_valid toggles 1/0 every cycle on the first scenario. Required response: identical writes, each one cycle after its odd beat; done 16 cycles after start.
- Config error: start with in_w=3. Required response: cfg_err pulse, busy=0, no writes. A following valid start runs normally.
- Reset mid-run plus address wrap: rst after the 3rd beat gives IDLE with all outputs 0. Rerun with base=0xFFF and ADDR_WIDTH=12; the second write lands at 0x000.
